// File: rtl/axi_lite_mem_slave.sv
// axi_lite_mem_slave
// AXI4-Lite-style word-addressed memory slave for the mriscvcore bus.
// Independent read and write engines, each with a programmable latency,
// byte-strobed RAM writes, a memory-mapped console byte port and
// out-of-bounds error pulses.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   AWvalid/AWready/AWdata/AWprot   write address channel (AWprot ignored)
//   Wvalid/Wready/Wdata/Wstrb       write data channel
//   Bvalid/Bready                   write response channel
//   ARvalid/ARready/ARdata/ARprot   read address channel (ARprot[2] latched)
//   Rvalid/RReady/Rdata             read data channel
//   console_valid/console_data      one-cycle pulse + byte on a console write
//   err_rd/err_wr                   one-cycle out-of-bounds pulses
//
// Optional build macro AXI_MEM_RANDOM_STALL_EN: a free-running xorshift64
// register randomly suppresses the readies and inserts stall cycles before
// read response and write commit. Functional results are unchanged.
module axi_lite_mem_slave #(
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    ADDR_WIDTH   = 32,
  parameter int                    MEM_WORDS    = 16384,
  parameter logic [ADDR_WIDTH-1:0] CONSOLE_ADDR = 32'h1000_0000,
  parameter int                    RD_LATENCY   = 1,
  parameter int                    WR_LATENCY   = 1,
  parameter string                 INIT_FILE    = ""
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    AWvalid,
  output logic                    AWready,
  input  logic [ADDR_WIDTH-1:0]   AWdata,
  input  logic [2:0]              AWprot,
  input  logic                    Wvalid,
  output logic                    Wready,
  input  logic [DATA_WIDTH-1:0]   Wdata,
  input  logic [DATA_WIDTH/8-1:0] Wstrb,
  output logic                    Bvalid,
  input  logic                    Bready,
  input  logic                    ARvalid,
  output logic                    ARready,
  input  logic [ADDR_WIDTH-1:0]   ARdata,
  input  logic [2:0]              ARprot,
  output logic                    Rvalid,
  input  logic                    RReady,
  output logic [DATA_WIDTH-1:0]   Rdata,
  output logic                    console_valid,
  output logic [7:0]              console_data,
  output logic                    err_rd,
  output logic                    err_wr
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int OFF    = $clog2(STRB_W);
  localparam int IDX_W  = $clog2(MEM_WORDS);

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} rd_state_e;
  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} wr_state_e;

  function automatic logic in_bounds(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] w;
    w = a >> OFF;
    return (w < ADDR_WIDTH'(MEM_WORDS)) && (a != CONSOLE_ADDR);
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
    return IDX_W'(a >> OFF);
  endfunction

  logic [DATA_WIDTH-1:0] mem_q [MEM_WORDS];

  logic stall_ar, stall_aw, stall_w, stall_rd, stall_wr;

`ifdef AXI_MEM_RANDOM_STALL_EN
  logic [63:0] lfsr_q;

  function automatic logic [63:0] xorshift64(input logic [63:0] x);
    logic [63:0] y;
    y = x ^ (x << 13);
    y = y ^ (y >> 7);
    y = y ^ (y << 17);
    return y;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= 64'd88172645463325252;
    else     lfsr_q <= xorshift64(lfsr_q);
  end

  assign stall_ar = lfsr_q[0];
  assign stall_aw = lfsr_q[1];
  assign stall_w  = lfsr_q[2];
  assign stall_rd = lfsr_q[3];
  assign stall_wr = lfsr_q[4];
`else
  assign stall_ar = 1'b0;
  assign stall_aw = 1'b0;
  assign stall_w  = 1'b0;
  assign stall_rd = 1'b0;
  assign stall_wr = 1'b0;
`endif

  // ---------------- read engine ----------------
  rd_state_e             r_state_q, r_state_d;
  logic [3:0]            r_cnt_q, r_cnt_d;
  logic [ADDR_WIDTH-1:0] ar_addr_q, rd_addr;
  logic                  ar_fetch_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  err_rd_q, ar_hs, rd_sample;

  // Readies are forced low while rst is held so reset shows all-zero outputs.
  assign ARready = (r_state_q == R_IDLE) && !rst && !stall_ar;
  assign ar_hs   = ARvalid && ARready;
  // Zero-latency reads sample with the address still on the bus.
  assign rd_addr = (r_state_q == R_IDLE) ? ARdata : ar_addr_q;

  always_comb begin
    r_state_d = r_state_q;
    r_cnt_d   = r_cnt_q;
    rd_sample = 1'b0;
    case (r_state_q)
      R_IDLE: if (ar_hs) begin
        if (RD_LATENCY == 0 && !stall_rd) begin
          rd_sample = 1'b1;
          r_state_d = R_RESP;
        end else begin
          r_cnt_d   = (RD_LATENCY == 0) ? 4'd1 : 4'(RD_LATENCY);
          r_state_d = R_WAIT;
        end
      end
      R_WAIT: begin
        if (r_cnt_q == 4'd1) begin
          if (!stall_rd) begin
            rd_sample = 1'b1;
            r_state_d = R_RESP;
          end
        end else begin
          r_cnt_d = r_cnt_q - 4'd1;
        end
      end
      R_RESP:  if (RReady) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state_q <= R_IDLE;
      r_cnt_q   <= '0;
      ar_fetch_q <= 1'b0;
      rdata_q   <= '0;
      err_rd_q  <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      r_cnt_q   <= r_cnt_d;
      err_rd_q  <= rd_sample && !in_bounds(rd_addr);
      if (ar_hs) ar_fetch_q <= ARprot[2];
      if (rd_sample) rdata_q <= in_bounds(rd_addr) ? mem_q[word_idx(rd_addr)] : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (ar_hs) ar_addr_q <= ARdata;
  end

  assign Rvalid = (r_state_q == R_RESP);
  assign Rdata  = rdata_q;
  assign err_rd = err_rd_q;

  // ---------------- write engine ----------------
  wr_state_e             w_state_q, w_state_d;
  logic [3:0]            w_cnt_q, w_cnt_d;
  logic                  aw_lat_q, w_lat_q, aw_hs, w_hs, commit, w_clear;
  logic [ADDR_WIDTH-1:0] aw_addr_q, eff_addr;
  logic [DATA_WIDTH-1:0] w_data_q, eff_data;
  logic [STRB_W-1:0]     w_strb_q, eff_strb;
  logic                  is_con, wr_inb;
  logic                  console_valid_q, err_wr_q;
  logic [7:0]            console_data_q;

  assign AWready = (w_state_q == W_IDLE) && !aw_lat_q && !rst && !stall_aw;
  assign Wready  = (w_state_q == W_IDLE) && !w_lat_q && !rst && !stall_w;
  assign aw_hs   = AWvalid && AWready;
  assign w_hs    = Wvalid && Wready;

  // A channel arriving in the commit cycle itself is taken straight off the bus.
  assign eff_addr = aw_lat_q ? aw_addr_q : AWdata;
  assign eff_data = w_lat_q ? w_data_q : Wdata;
  assign eff_strb = w_lat_q ? w_strb_q : Wstrb;
  assign is_con   = (eff_addr == CONSOLE_ADDR);
  assign wr_inb   = in_bounds(eff_addr);

  always_comb begin
    w_state_d = w_state_q;
    w_cnt_d   = w_cnt_q;
    commit    = 1'b0;
    w_clear   = 1'b0;
    case (w_state_q)
      W_IDLE: if ((aw_lat_q || aw_hs) && (w_lat_q || w_hs)) begin
        if (WR_LATENCY == 0 && !stall_wr) begin
          commit    = 1'b1;
          w_state_d = W_RESP;
        end else begin
          w_cnt_d   = (WR_LATENCY == 0) ? 4'd1 : 4'(WR_LATENCY);
          w_state_d = W_WAIT;
        end
      end
      W_WAIT: begin
        if (w_cnt_q == 4'd1) begin
          if (!stall_wr) begin
            commit    = 1'b1;
            w_state_d = W_RESP;
          end
        end else begin
          w_cnt_d = w_cnt_q - 4'd1;
        end
      end
      W_RESP: if (Bready) begin
        w_clear   = 1'b1;
        w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state_q       <= W_IDLE;
      w_cnt_q         <= '0;
      aw_lat_q        <= 1'b0;
      w_lat_q         <= 1'b0;
      console_valid_q <= 1'b0;
      console_data_q  <= '0;
      err_wr_q        <= 1'b0;
    end else begin
      w_state_q       <= w_state_d;
      w_cnt_q         <= w_cnt_d;
      if (w_clear) begin
        aw_lat_q <= 1'b0;
        w_lat_q  <= 1'b0;
      end else begin
        if (aw_hs) aw_lat_q <= 1'b1;
        if (w_hs)  w_lat_q  <= 1'b1;
      end
      console_valid_q <= commit && is_con;
      err_wr_q        <= commit && !wr_inb && !is_con;
      if (commit && is_con) console_data_q <= eff_data[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (aw_hs) aw_addr_q <= AWdata;
    if (w_hs) begin
      w_data_q <= Wdata;
      w_strb_q <= Wstrb;
    end
  end

  // A commit coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (commit && wr_inb && !rst) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (eff_strb[b]) mem_q[word_idx(eff_addr)][b*8 +: 8] <= eff_data[b*8 +: 8];
      end
    end
  end

  assign Bvalid        = (w_state_q == W_RESP);
  assign console_valid = console_valid_q;
  assign console_data  = console_data_q;
  assign err_wr        = err_wr_q;

  // Protection bits carry no function in this slave.
  logic unused_prot;
  assign unused_prot = ^{AWprot, ARprot[1:0], ar_fetch_q};

endmodule

// File: tb/tb_axi_lite_mem_slave.sv
// Self-checking bench for axi_lite_mem_slave (default parameters).
module tb_axi_lite_mem_slave;
  localparam logic [31:0] CON = 32'h1000_0000;
  localparam int          MW  = 16384;

  logic        clk = 1'b0, rst = 1'b1;
  logic        AWvalid = 0, AWready, Wvalid = 0, Wready, Bvalid, Bready = 0;
  logic        ARvalid = 0, ARready, Rvalid, RReady = 0;
  logic [31:0] AWdata = 0, Wdata = 0, ARdata = 0, Rdata;
  logic [2:0]  AWprot = 0, ARprot = 0;
  logic [3:0]  Wstrb = 0;
  logic        console_valid, err_rd, err_wr;
  logic [7:0]  console_data;

  axi_lite_mem_slave dut (
    .clk(clk), .rst(rst),
    .AWvalid(AWvalid), .AWready(AWready), .AWdata(AWdata), .AWprot(AWprot),
    .Wvalid(Wvalid), .Wready(Wready), .Wdata(Wdata), .Wstrb(Wstrb),
    .Bvalid(Bvalid), .Bready(Bready),
    .ARvalid(ARvalid), .ARready(ARready), .ARdata(ARdata), .ARprot(ARprot),
    .Rvalid(Rvalid), .RReady(RReady), .Rdata(Rdata),
    .console_valid(console_valid), .console_data(console_data),
    .err_rd(err_rd), .err_wr(err_wr)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0, n_bad = 0;
  int          con_cnt = 0, err_wr_cnt = 0, err_rd_cnt = 0;
  logic [7:0]  con_last = 0;
  logic [31:0] ref_mem [int];

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  function automatic bit addr_inb(input logic [31:0] a);
    return ((a >> 2) < MW) && (a != CON);
  endfunction

  task automatic tick();
    @(posedge clk); #1;
    if (console_valid) begin con_cnt++; con_last = console_data; end
    if (err_wr) err_wr_cnt++;
    if (err_rd) err_rd_cnt++;
  endtask

  task automatic bus_read(input logic [31:0] addr, input int hold,
                          output logic [31:0] data, output int lat, output bit err_at_rise,
                          output bit stable_ok, output bit ar_low_ok, output bit timeout);
    bit hs;
    int n;
    timeout = 0; stable_ok = 1; ar_low_ok = 1; err_at_rise = 0; data = '0; lat = 0;
    err_rd_cnt = 0;
    ARdata = addr; ARprot = 3'($urandom); ARvalid = 1;
    hs = 0; n = 0;
    while (!hs && n < 200) begin
      @(negedge clk); hs = ARready;
      tick(); n++;
    end
    ARvalid = 0;
    if (!hs) begin timeout = 1; return; end
    lat = 1;
    while (!Rvalid && lat < 200) begin tick(); lat++; end
    if (!Rvalid) begin timeout = 1; return; end
    data = Rdata; err_at_rise = err_rd;
    repeat (hold) begin
      if (ARready) ar_low_ok = 0;
      tick();
      if (!Rvalid || Rdata !== data) stable_ok = 0;
    end
    if (ARready) ar_low_ok = 0;
    RReady = 1; tick(); RReady = 0;
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_st, input int w_st, input int bhold,
                           output int nb, output bit hold_ok, output bit timeout);
    bit awd, wd, a_now, w_now;
    int c, n;
    con_cnt = 0; err_wr_cnt = 0; nb = 0; hold_ok = 1; timeout = 0;
    AWdata = addr; AWprot = 3'($urandom); Wdata = data; Wstrb = strb;
    awd = 0; wd = 0; c = 0;
    while (!(awd && wd) && c < 200) begin
      AWvalid = !awd && (c >= aw_st);
      Wvalid  = !wd && (c >= w_st);
      @(negedge clk); a_now = AWvalid && AWready; w_now = Wvalid && Wready;
      tick(); awd |= a_now; wd |= w_now; c++;
    end
    AWvalid = 0; Wvalid = 0;
    if (!(awd && wd)) begin timeout = 1; return; end
    n = 0;
    while (!Bvalid && n < 200) begin tick(); n++; end
    if (!Bvalid) begin timeout = 1; return; end
    nb = 1;
    repeat (bhold) begin tick(); if (!Bvalid) hold_ok = 0; end
    Bready = 1; tick(); Bready = 0;
    repeat (2) begin if (Bvalid) nb++; tick(); end
  endtask

  task automatic fail_timeout(input string name);
    n_cmp++; n_bad++;
    $display("FAIL %s: handshake timed out (got no response, required one)", name);
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({ARready, AWready, Wready, Bvalid, Rvalid, Rdata, console_valid, console_data, err_rd, err_wr} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %b/%b/%b/%b/%b Rdata=%h cv=%b cd=%h er=%b ew=%b required all 0",
               ARready, AWready, Wready, Bvalid, Rvalid, Rdata, console_valid, console_data, err_rd, err_wr);
    end
    rst = 0;
    tick();
`ifndef AXI_MEM_RANDOM_STALL_EN
    n_cmp++;
    if ({ARready, AWready, Wready} !== 3'b111) begin
      n_bad++; $display("FAIL idle_ready: got %b required 111", {ARready, AWready, Wready});
    end
`endif
  endtask

  task automatic test_read_latency();
    logic [31:0] d; int lat, nb; bit e, st, al, hk, to;
    bus_write(32'h10, 32'hDEADBEEF, 4'hF, 0, 0, 0, nb, hk, to);
    if (to) fail_timeout("lat_setup");
    ref_mem[4] = 32'hDEADBEEF;
    bus_read(32'h10, 3, d, lat, e, st, al, to);
    if (to) fail_timeout("lat_read");
`ifndef AXI_MEM_RANDOM_STALL_EN
    n_cmp++;
    if (lat !== 2) begin n_bad++; $display("FAIL rd_latency: got %0d cycles required 2", lat); end
`endif
    n_cmp++;
    if (d !== 32'hDEADBEEF || e !== 1'b0) begin
      n_bad++; $display("FAIL rd_data: got %h err=%b required deadbeef err=0", d, e);
    end
    n_cmp++;
    if (!st || !al) begin
      n_bad++; $display("FAIL rd_hold: got stable=%b arready_low=%b required 1/1", st, al);
    end
  endtask

  task automatic test_strobe();
    logic [31:0] d; int lat, nb; bit e, st, al, hk, to;
    bus_write(32'h20, 32'hAAAAAAAA, 4'hF, 0, 0, 0, nb, hk, to);
    bus_write(32'h20, 32'h11223344, 4'b0101, 0, 0, 5, nb, hk, to);
    if (to) fail_timeout("strb_write");
    n_cmp++;
    if (!hk || nb !== 1) begin
      n_bad++; $display("FAIL b_hold: got held=%b responses=%0d required 1/1", hk, nb);
    end
    ref_mem[8] = 32'hAA22AA44;
    bus_read(32'h20, 0, d, lat, e, st, al, to);
    n_cmp++;
    if (d !== 32'hAA22AA44) begin n_bad++; $display("FAIL strb_data: got %h required aa22aa44", d); end
  endtask

  task automatic test_order();
    logic [31:0] d; int lat, nb; bit e, st, al, hk, to;
    bus_write(32'h30, 32'h0BADF00D, 4'hF, 3, 0, 0, nb, hk, to);
    n_cmp++;
    if (to || nb !== 1) begin n_bad++; $display("FAIL w_first_resp: got %0d responses required 1", nb); end
    bus_write(32'h34, 32'h600DCAFE, 4'hF, 0, 0, 0, nb, hk, to);
    n_cmp++;
    if (to || nb !== 1) begin n_bad++; $display("FAIL same_cycle_resp: got %0d responses required 1", nb); end
    ref_mem[12] = 32'h0BADF00D; ref_mem[13] = 32'h600DCAFE;
    bus_read(32'h30, 0, d, lat, e, st, al, to);
    n_cmp++;
    if (d !== 32'h0BADF00D) begin n_bad++; $display("FAIL w_first_data: got %h required 0badf00d", d); end
    bus_read(32'h34, 0, d, lat, e, st, al, to);
    n_cmp++;
    if (d !== 32'h600DCAFE) begin n_bad++; $display("FAIL same_cycle_data: got %h required 600dcafe", d); end
  endtask

  task automatic test_console();
    logic [31:0] d; int lat, nb; bit e, st, al, hk, to;
    bus_write(CON, 32'h0000004F, 4'hF, 0, 0, 0, nb, hk, to);
    n_cmp++;
    if (to || con_cnt !== 1 || con_last !== 8'h4F || err_wr_cnt !== 0 || nb !== 1) begin
      n_bad++;
      $display("FAIL console: got pulses=%0d data=%h err_wr=%0d resp=%0d required 1/4f/0/1",
               con_cnt, con_last, err_wr_cnt, nb);
    end
    bus_read(32'h10, 0, d, lat, e, st, al, to);
    n_cmp++;
    if (d !== ref_mem[4]) begin n_bad++; $display("FAIL console_ram: got %h required %h", d, ref_mem[4]); end
  endtask

  task automatic test_oob();
    logic [31:0] d; int lat, nb; bit e, st, al, hk, to;
    bus_read(32'h0001_0000, 2, d, lat, e, st, al, to);
    n_cmp++;
    if (to || d !== 32'h0 || e !== 1'b1 || err_rd_cnt !== 1) begin
      n_bad++; $display("FAIL oob_read: got %h err_rise=%b pulses=%0d required 0/1/1", d, e, err_rd_cnt);
    end
    bus_write(32'h0001_0000, 32'h12345678, 4'hF, 0, 0, 0, nb, hk, to);
    n_cmp++;
    if (to || err_wr_cnt !== 1 || nb !== 1 || con_cnt !== 0) begin
      n_bad++; $display("FAIL oob_write: got err_wr=%0d resp=%0d console=%0d required 1/1/0",
                        err_wr_cnt, nb, con_cnt);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d; int lat, nb, n; bit e, st, al, hk, to, hs, awd, wd, a_now, w_now;
    bus_write(32'h50, 32'h12345678, 4'hF, 0, 0, 0, nb, hk, to);
    ref_mem[20] = 32'h12345678;
    // reset with a read waiting out its latency
    ARdata = 32'h50; ARvalid = 1; hs = 0; n = 0;
    while (!hs && n < 200) begin @(negedge clk); hs = ARready; tick(); n++; end
    ARvalid = 0;
    if (!hs) fail_timeout("rst_rd_ar");
    rst = 1; @(posedge clk); #1;
    n_cmp++;
    if ({ARready, AWready, Wready, Bvalid, Rvalid, Rdata, console_valid, err_rd, err_wr} !== '0) begin
      n_bad++; $display("FAIL rst_in_rwait: got Rvalid=%b Rdata=%h ready=%b required all 0",
                        Rvalid, Rdata, {ARready, AWready, Wready});
    end
    rst = 0; tick();
    // reset with a write waiting for its commit
    AWdata = 32'h50; Wdata = 32'hCAFEF00D; Wstrb = 4'hF; awd = 0; wd = 0; n = 0;
    while (!(awd && wd) && n < 200) begin
      AWvalid = !awd; Wvalid = !wd;
      @(negedge clk); a_now = AWvalid && AWready; w_now = Wvalid && Wready;
      tick(); awd |= a_now; wd |= w_now; n++;
    end
    AWvalid = 0; Wvalid = 0;
    if (!(awd && wd)) fail_timeout("rst_wr_hs");
    rst = 1; @(posedge clk); #1;
    n_cmp++;
    if ({ARready, AWready, Wready, Bvalid, Rvalid, Rdata, console_valid, err_rd, err_wr} !== '0) begin
      n_bad++; $display("FAIL rst_in_wwait: got Bvalid=%b ready=%b required all 0",
                        Bvalid, {ARready, AWready, Wready});
    end
    rst = 0; tick();
    bus_read(32'h50, 0, d, lat, e, st, al, to);
    n_cmp++;
    if (to || d !== 32'h12345678) begin
      n_bad++; $display("FAIL rst_word_kept: got %h required 12345678", d);
    end
  endtask

  task automatic test_random();
    logic [31:0] d, a, wd, exp_d; logic [3:0] s; int lat, nb, sel, idx;
    bit e, st, al, hk, to, inb, con;
    for (int i = 0; i < 64; i++) begin
      wd = $urandom;
      bus_write(32'(i * 4), wd, 4'hF, 0, 0, 0, nb, hk, to);
      if (to) fail_timeout("rand_fill");
      ref_mem[i] = wd;
    end
    for (int t = 0; t < 1000; t++) begin
      sel = $urandom_range(0, 19);
      if (sel == 0)      a = CON;
      else if (sel == 1) a = 32'h0001_0000 + 32'($urandom_range(0, 255)) * 4;
      else               a = (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(0, 3));
      inb = addr_inb(a); con = (a == CON); idx = int'(a >> 2);
      if ($urandom_range(0, 99) < 45) begin
        bus_read(a, $urandom_range(0, 3), d, lat, e, st, al, to);
        exp_d = inb ? ref_mem[idx] : 32'h0;
        n_cmp++;
        if (to || d !== exp_d || e !== !inb || !st) begin
          n_bad++; $display("FAIL rand_read[%0d]: addr %h got %h err=%b required %h err=%b",
                            t, a, d, e, exp_d, !inb);
        end
      end else begin
        wd = $urandom; s = 4'($urandom);
        bus_write(a, wd, s, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), nb, hk, to);
        if (inb) ref_mem[idx] = merge(ref_mem[idx], wd, s);
        n_cmp++;
        if (to || nb !== 1 || !hk || con_cnt !== int'(con) || err_wr_cnt !== int'(!inb && !con) ||
            (con && con_last !== wd[7:0])) begin
          n_bad++; $display("FAIL rand_write[%0d]: addr %h got resp=%0d console=%0d err_wr=%0d required 1/%0d/%0d",
                            t, a, nb, con_cnt, err_wr_cnt, con, !inb && !con);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_read_latency();
    test_strobe();
    test_order();
    test_console();
    test_oob();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
